// File: rtl/addsub_sequencer.sv
// addsub_sequencer: valid/ready sequencer around an external 4-bit adder/subtractor,
// with settle-time capture, result flags and a chaining accumulator.
`default_nettype none

module addsub_sequencer #(
  parameter int         SETTLE_CYCLES = 1,
  parameter logic [3:0] ACC_INIT      = 4'h0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [1:0] in_op,
  input  logic [3:0] in_a,
  input  logic [3:0] in_b,
  output logic [3:0] as_a,
  output logic [3:0] as_b,
  output logic       as_m,
  input  logic [3:0] as_d,
  input  logic       as_bout,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [3:0] out_d,
  output logic       out_carry,
  output logic       out_ovf,
  output logic       out_zero,
  output logic [3:0] acc
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam logic [2:0] LAST_CNT = 3'(SETTLE_CYCLES - 1);

  state_t     state, state_nxt;
  logic [2:0] cnt;
  logic       acc_op;
  logic       accept;
  logic       capture;
  logic [3:0] b_eff;
  logic       ovf;

  // Overflow is judged against the operand actually seen by the adder.
  assign b_eff = as_b ^ {4{as_m}};
  assign ovf   = (as_a[3] == b_eff[3]) && (as_d[3] != as_a[3]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    accept    = 1'b0;
    capture   = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          accept    = 1'b1;
          state_nxt = DRIVE;
        end
      end
      DRIVE: begin
        if (cnt == LAST_CNT) begin
          capture   = 1'b1;
          state_nxt = HOLD;
        end
      end
      HOLD: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      as_a      <= 4'h0;
      as_b      <= 4'h0;
      as_m      <= 1'b0;
      acc_op    <= 1'b0;
      cnt       <= 3'd0;
      out_d     <= 4'h0;
      out_carry <= 1'b0;
      out_ovf   <= 1'b0;
      out_zero  <= 1'b0;
      acc       <= ACC_INIT;
    end else if (accept) begin
      as_a   <= in_op[1] ? acc : in_a;
      as_b   <= in_b;
      as_m   <= in_op[0];
      acc_op <= in_op[1];
      cnt    <= 3'd0;
    end else if (state == DRIVE) begin
      cnt <= cnt + 3'd1;
      if (capture) begin
        out_d     <= as_d;
        out_carry <= as_bout;
        out_ovf   <= ovf;
        out_zero  <= (as_d == 4'h0);
        if (acc_op) acc <= as_d;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_addsub_sequencer.sv
// tb_addsub_sequencer: directed checks of two sequencer instances (settle 1 and 3)
// each wrapped around a behavioural 4-bit adder/subtractor.
`default_nettype none

module tb_addsub_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid1 = 1'b0, in_valid3 = 1'b0;
  logic [1:0] in_op = 2'b00;
  logic [3:0] in_a = 4'h0, in_b = 4'h0;
  logic       out_ready = 1'b1;

  logic       in_ready1, as_m1, as_bout1, out_valid1, out_carry1, out_ovf1, out_zero1;
  logic [3:0] as_a1, as_b1, as_d1, out_d1, acc1;
  logic       in_ready3, as_m3, as_bout3, out_valid3, out_carry3, out_ovf3, out_zero3;
  logic [3:0] as_a3, as_b3, as_d3, out_d3, acc3;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  // Subtraction as a + ~b + 1; carry out doubles as the "no borrow" bit.
  assign {as_bout1, as_d1} = {1'b0, as_a1} + {1'b0, as_b1 ^ {4{as_m1}}} + {4'b0, as_m1};
  assign {as_bout3, as_d3} = {1'b0, as_a3} + {1'b0, as_b3 ^ {4{as_m3}}} + {4'b0, as_m3};

  addsub_sequencer #(.SETTLE_CYCLES(1), .ACC_INIT(4'h0)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1), .in_op(in_op),
    .in_a(in_a), .in_b(in_b), .as_a(as_a1), .as_b(as_b1), .as_m(as_m1), .as_d(as_d1),
    .as_bout(as_bout1), .out_valid(out_valid1), .out_ready(out_ready), .out_d(out_d1),
    .out_carry(out_carry1), .out_ovf(out_ovf1), .out_zero(out_zero1), .acc(acc1)
  );

  addsub_sequencer #(.SETTLE_CYCLES(3), .ACC_INIT(4'h5)) u_dut3 (
    .clk(clk), .rst(rst), .in_valid(in_valid3), .in_ready(in_ready3), .in_op(in_op),
    .in_a(in_a), .in_b(in_b), .as_a(as_a3), .as_b(as_b3), .as_m(as_m3), .as_d(as_d3),
    .as_bout(as_bout3), .out_valid(out_valid3), .out_ready(out_ready), .out_d(out_d3),
    .out_carry(out_carry3), .out_ovf(out_ovf3), .out_zero(out_zero3), .acc(acc3)
  );

  // One transaction on the settle-1 instance with out_ready held high; returns observations.
  task automatic xact1(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b,
                       output logic early_v, output logic late_v, output logic m,
                       output logic [3:0] asa, output logic [3:0] d, output logic c,
                       output logic v, output logic z, output logic [3:0] accv,
                       output logic rdy_after);
    @(negedge clk);
    in_op = op; in_a = a; in_b = b; in_valid1 = 1'b1;
    @(posedge clk); #1;
    in_valid1 = 1'b0;
    m = as_m1; asa = as_a1; early_v = out_valid1;
    @(posedge clk); #1;
    late_v = out_valid1; d = out_d1; c = out_carry1; v = out_ovf1; z = out_zero1; accv = acc1;
    @(posedge clk); #1;
    rdy_after = in_ready1 & ~out_valid1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    vectors++; if (in_ready1 !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready: got %b want 1", in_ready1); end
    vectors++; if (out_valid1 !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid: got %b want 0", out_valid1); end
    vectors++; if ({as_a1, as_b1, as_m1, out_d1} !== 13'h0) begin miscompares++; $display("FAIL reset_regs: got %h want 0", {as_a1, as_b1, as_m1, out_d1}); end
    vectors++; if (acc1 !== 4'h0) begin miscompares++; $display("FAIL reset_acc1: got %h want 0", acc1); end
    vectors++; if (acc3 !== 4'h5) begin miscompares++; $display("FAIL reset_acc3: got %h want 5", acc3); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_add();
    logic ev, lv, m, c, v, z, rdy;
    logic [3:0] asa, d, ac;
    xact1(2'b00, 4'h3, 4'h5, ev, lv, m, asa, d, c, v, z, ac, rdy);
    vectors++; if (m !== 1'b0) begin miscompares++; $display("FAIL add_m: got %b want 0", m); end
    vectors++; if (ev !== 1'b0 || lv !== 1'b1) begin miscompares++; $display("FAIL add_latency: got %b%b want 01", ev, lv); end
    vectors++; if ({d, c, v, z} !== {4'h8, 1'b0, 1'b1, 1'b0}) begin miscompares++; $display("FAIL add_result: got d=%h c%b v%b z%b want d=8 c0 v1 z0", d, c, v, z); end
    vectors++; if (rdy !== 1'b1) begin miscompares++; $display("FAIL add_ready_after: got %b want 1", rdy); end
  endtask

  task automatic test_sub();
    logic ev, lv, m, c, v, z, rdy;
    logic [3:0] asa, d, ac;
    xact1(2'b01, 4'h5, 4'h5, ev, lv, m, asa, d, c, v, z, ac, rdy);
    vectors++; if (m !== 1'b1) begin miscompares++; $display("FAIL sub55_m: got %b want 1", m); end
    vectors++; if ({d, c, v, z} !== {4'h0, 1'b1, 1'b0, 1'b1}) begin miscompares++; $display("FAIL sub55_result: got d=%h c%b v%b z%b want d=0 c1 v0 z1", d, c, v, z); end
    xact1(2'b01, 4'h2, 4'h7, ev, lv, m, asa, d, c, v, z, ac, rdy);
    vectors++; if ({d, c, v, z} !== {4'hB, 1'b0, 1'b0, 1'b0}) begin miscompares++; $display("FAIL sub27_result: got d=%h c%b v%b z%b want d=b c0 v0 z0", d, c, v, z); end
    xact1(2'b01, 4'h8, 4'h1, ev, lv, m, asa, d, c, v, z, ac, rdy);
    vectors++; if ({d, c, v, z} !== {4'h7, 1'b1, 1'b1, 1'b0}) begin miscompares++; $display("FAIL sub81_result: got d=%h c%b v%b z%b want d=7 c1 v1 z0", d, c, v, z); end
    vectors++; if (acc1 !== 4'h0) begin miscompares++; $display("FAIL sub_acc_untouched: got %h want 0", acc1); end
  endtask

  task automatic test_acc_chain();
    logic ev, lv, m, c, v, z, rdy;
    logic [3:0] asa, d, ac;
    xact1(2'b10, 4'hA, 4'h9, ev, lv, m, asa, d, c, v, z, ac, rdy);
    vectors++; if (asa !== 4'h0) begin miscompares++; $display("FAIL acc1_as_a: got %h want 0", asa); end
    vectors++; if ({ac, d, c, v} !== {4'h9, 4'h9, 1'b0, 1'b0}) begin miscompares++; $display("FAIL acc1_result: got acc=%h d=%h c%b v%b want acc=9 d=9 c0 v0", ac, d, c, v); end
    xact1(2'b10, 4'hA, 4'h9, ev, lv, m, asa, d, c, v, z, ac, rdy);
    vectors++; if ({ac, d, c, v} !== {4'h2, 4'h2, 1'b1, 1'b1}) begin miscompares++; $display("FAIL acc2_result: got acc=%h d=%h c%b v%b want acc=2 d=2 c1 v1", ac, d, c, v); end
    xact1(2'b11, 4'hA, 4'h3, ev, lv, m, asa, d, c, v, z, ac, rdy);
    vectors++; if ({ac, d, c, m} !== {4'hF, 4'hF, 1'b0, 1'b1}) begin miscompares++; $display("FAIL acc3_result: got acc=%h d=%h c%b m%b want acc=f d=f c0 m1", ac, d, c, m); end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    @(negedge clk);
    in_op = 2'b00; in_a = 4'h6; in_b = 4'h7; in_valid3 = 1'b1;
    @(posedge clk); #1;
    in_valid3 = 1'b0;
    for (int i = 1; i <= 2; i++) begin
      @(posedge clk); #1;
      vectors++; if (out_valid3 !== 1'b0) begin miscompares++; $display("FAIL settle3_early_valid%0d: got %b want 0", i, out_valid3); end
    end
    @(posedge clk); #1;
    vectors++; if ({out_valid3, out_d3, out_carry3, out_ovf3, out_zero3} !== {1'b1, 4'hD, 1'b0, 1'b1, 1'b0}) begin
      miscompares++; $display("FAIL settle3_capture: got v%b d=%h c%b o%b z%b want v1 d=d c0 o1 z0", out_valid3, out_d3, out_carry3, out_ovf3, out_zero3);
    end
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      in_valid3 = (i == 2);
      in_op = 2'b11; in_a = 4'h1; in_b = 4'h1;
      @(posedge clk); #1;
      vectors++; if ({out_valid3, in_ready3, out_d3, out_ovf3, as_a3, as_m3} !== {1'b1, 1'b0, 4'hD, 1'b1, 4'h6, 1'b0}) begin
        miscompares++; $display("FAIL hold_stable%0d: got v%b r%b d=%h o%b a=%h m%b", i, out_valid3, in_ready3, out_d3, out_ovf3, as_a3, as_m3);
      end
    end
    @(negedge clk);
    in_valid3 = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    vectors++; if ({out_valid3, in_ready3} !== 2'b01) begin miscompares++; $display("FAIL handshake: got v%b r%b want v0 r1", out_valid3, in_ready3); end
    @(posedge clk); #1;
    vectors++; if ({out_valid3, out_d3, acc3} !== {1'b0, 4'hD, 4'h5}) begin miscompares++; $display("FAIL after_handshake: got v%b d=%h acc=%h want v0 d=d acc=5", out_valid3, out_d3, acc3); end
  endtask

  task automatic test_reset_abort();
    logic ev, lv, m, c, v, z, rdy;
    logic [3:0] asa, d, ac;
    @(negedge clk);
    in_op = 2'b01; in_a = 4'h9; in_b = 4'h4; in_valid1 = 1'b1;
    @(posedge clk); #1;
    in_valid1 = 1'b0;
    rst = 1'b1;
    #1;
    vectors++; if ({out_valid1, in_ready1, acc1, as_a1, as_b1, as_m1} !== {1'b0, 1'b1, 4'h0, 4'h0, 4'h0, 1'b0}) begin
      miscompares++; $display("FAIL reset_abort: got v%b r%b acc=%h a=%h b=%h m%b", out_valid1, in_ready1, acc1, as_a1, as_b1, as_m1);
    end
    @(posedge clk); #1;
    vectors++; if (out_valid1 !== 1'b0) begin miscompares++; $display("FAIL reset_no_partial: got %b want 0", out_valid1); end
    @(negedge clk);
    rst = 1'b0;
    xact1(2'b00, 4'h1, 4'h1, ev, lv, m, asa, d, c, v, z, ac, rdy);
    vectors++; if ({ev, lv, d} !== {1'b0, 1'b1, 4'h2}) begin miscompares++; $display("FAIL post_reset_add: got ev%b lv%b d=%h want ev0 lv1 d=2", ev, lv, d); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_acc_chain();
    test_backpressure();
    test_reset_abort();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/addsub_sequencer.md
Name: addsub_sequencer

Overview:
- Sequential controller that wraps the team's combinational 4-bit adder/subtractor.
- Upstream side: accepts operation requests over a valid/ready handshake. It registers the operands and drives the adder/subtractor's a, b and M inputs.
- Downstream side: after a programmable settle time, captures d and bout, derives flags and presents the result over a second valid/ready handshake.
- Also keeps a 4-bit accumulator for chained add/sub operations.

Parameters:
- SETTLE_CYCLES, 1: cycles operands are held on the adder inputs before capture; legal range 1..7.
- ACC_INIT, 4'h0: accumulator value after reset.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  request valid
- in_ready  out  1  request accepted when in_valid & in_ready at a clk edge
- in_op  in  2  00 add a+b; 01 sub a-b; 10 acc+b; 11 acc-b
- in_a  in  4  operand A; ignored for in_op[1]=1
- in_b  in  4  operand B
- as_a  out  4  to adder/subtractor a
- as_b  out  4  to adder/subtractor b
- as_m  out  1  to adder/subtractor M; 0 add, 1 sub
- as_d  in  4  from adder/subtractor d
- as_bout  in  1  from adder/subtractor bout
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out_d  out  4  captured result
- out_carry  out  1  captured bout; for sub, 1 = no borrow (A>=B unsigned)
- out_ovf  out  1  signed (two's complement) overflow
- out_zero  out  1  out_d == 0
- acc  out  4  current accumulator

Behaviour:
- Reset (async, immediate):
  - state=IDLE, in_ready=1, out_valid=0.
  - out_d/out_carry/out_ovf/out_zero=0; as_a/as_b/as_m=0; settle counter=0; acc=ACC_INIT.
  - Reset mid-operation aborts the transaction; no partial result is emitted.
- States:
  - IDLE: in_ready=1. On in_valid at an edge:
    - as_a <= (in_op[1] ? acc : in_a); as_b <= in_b; as_m <= in_op[0].
    - Latch the op; counter <= 0; go to DRIVE.
  - DRIVE: in_ready=0; as_* stable. Counter increments each edge.
    - On the edge where counter == SETTLE_CYCLES-1: capture as_d into out_d and as_bout into out_carry; compute flags.
    - If the latched op is acc-type, acc <= as_d on the same edge. Go to HOLD.
  - HOLD: out_valid=1, in_ready=0. Outputs are stable until out_valid & out_ready at an edge. That edge → IDLE, out_valid=0, result fields retained.
- Latency: acceptance edge k; capture at edge k+SETTLE_CYCLES; out_valid high from edge k+SETTLE_CYCLES. Minimum issue interval is SETTLE_CYCLES+2 cycles with out_ready held at 1.
- Flags:
  - Overflow uses the effective B, Beff = as_b XOR {4{as_m}}: out_ovf = (as_a[3]==Beff[3]) & (as_d[3]!=as_a[3]).
  - out_zero = (as_d==4'h0).
- Arithmetic: all values are modulo 16; wrap-around is silent apart from out_carry/out_ovf. The acc update uses the captured d regardless of flags.
- Rejected input: in_valid while not in IDLE is ignored and has no effect; the requester must hold it.
- as_* hold their last values in IDLE and HOLD; they change only on acceptance.
- acc changes only on the capture of an acc-type op, or on reset.

Test Plan:
1. SETTLE_CYCLES=1, out_ready=1; add a=3, b=5:
   - as_m=0.
   - out_d=8, out_carry=0, out_ovf=1, out_zero=0.
   - out_valid rises exactly 1 edge after acceptance; in_ready returns 1 the cycle after the out handshake.
2. sub a=5, b=5 → as_m=1, out_d=0, out_carry=1, out_zero=1, out_ovf=0.
3. sub a=2, b=7 → out_d=4'hB, out_carry=0, out_ovf=0. Also sub a=8, b=1 → out_d=7, out_ovf=1, out_carry=1.
4. Accumulator chain, ACC_INIT=0:
   - acc+9 → acc=9, out_ovf=0.
   - acc+9 → acc=2, out_carry=1, out_ovf=1.
   - acc-3 → acc=4'hF, out_carry=0.
   - in_a is driven to 4'hA throughout and must not affect any result.
5. SETTLE_CYCLES=3, out_ready=0 for 6 cycles:
   - Capture occurs 3 edges after acceptance.
   - out_valid and all result fields stay stable; in_ready=0.
   - A second in_valid pulse is ignored.
   - After out_ready=1: exactly one handshake, then IDLE.
6. Assert rst during DRIVE of a sub 9-4 → immediately out_valid=0, in_ready=1, acc=ACC_INIT, as_*=0. After release, add 1+1 → out_d=2 with normal latency.
